// File: rtl/pipe_multdiv_ctrl_if.sv
// ============================================================================
// Module      : pipe_multdiv_ctrl_if
// Description : Pipeline / multdiv-unit signal bundle for pipe_multdiv_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_multdiv_ctrl_if;
  logic        dx_valid;
  logic        dx_is_mul;
  logic        dx_is_div;
  logic [31:0] dx_a;
  logic [31:0] dx_b;
  logic [4:0]  dx_rd;
  logic        flush;

  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic        md_rdy;
  logic [31:0] md_result;
  logic        md_exc;

  logic        stall;
  logic        xm_bubble;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_timeout;

  // Controller side
  modport slave (
    input  dx_valid, dx_is_mul, dx_is_div, dx_a, dx_b, dx_rd, flush,
    input  md_rdy, md_result, md_exc,
    output md_a, md_b, md_ctrl_mult, md_ctrl_div,
    output stall, xm_bubble, res_valid, res_data, res_rd, res_timeout
  );

  // Pipeline / multdiv-unit side
  modport master (
    output dx_valid, dx_is_mul, dx_is_div, dx_a, dx_b, dx_rd, flush,
    output md_rdy, md_result, md_exc,
    input  md_a, md_b, md_ctrl_mult, md_ctrl_div,
    input  stall, xm_bubble, res_valid, res_data, res_rd, res_timeout
  );
endinterface

`default_nettype wire

// File: rtl/pipe_multdiv_ctrl.sv
// ============================================================================
// Module      : pipe_multdiv_ctrl
// Description : Stalls the pipeline around a multi-cycle mul/div operation,
//               with timeout, exception and flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_multdiv_ctrl #(
  parameter int MAX_CYCLES = 40,
  parameter int STATUS_REG = 30
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  pipe_multdiv_ctrl_if.slave bus
);

  localparam logic [7:0]  c_last_cnt  = 8'(MAX_CYCLES - 1);
  localparam logic [4:0]  c_status_rd = 5'(STATUS_REG);
  localparam logic [31:0] c_exc_mul   = 32'd4;
  localparam logic [31:0] c_exc_div   = 32'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_is_div;
  logic [4:0]  r_rd;
  logic [31:0] r_md_a;
  logic [31:0] r_md_b;
  logic [31:0] r_res_data;
  logic [4:0]  r_res_rd;
  logic        r_res_timeout;

  logic w_trigger;
  logic w_stall;
  logic w_load;
  logic w_capture;
  logic w_timeout;
  logic w_start_mul;
  logic w_start_div;
  logic w_res_valid;
  logic w_exc_path;

  // rst_n gates the trigger so stall stays low while reset is held
  assign w_trigger = rst_n & bus.dx_valid & (bus.dx_is_mul | bus.dx_is_div) & ~bus.flush;

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_start_mul = 1'b0;
    w_start_div = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_stall     = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_stall     = 1'b1;
        w_start_mul = ~r_is_div;
        w_start_div = r_is_div;
        w_state_nxt = bus.flush ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
        end else if (bus.md_rdy) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == c_last_cnt) begin
          w_capture   = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_res_valid = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Exception results go to the status register instead of rd
  assign w_exc_path = w_timeout | (bus.md_rdy & bus.md_exc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_is_div      <= 1'b0;
      r_rd          <= 5'd0;
      r_md_a        <= 32'd0;
      r_md_b        <= 32'd0;
      r_res_data    <= 32'd0;
      r_res_rd      <= 5'd0;
      r_res_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_START) begin
        r_cnt <= 8'd0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_load) begin
        r_md_a   <= bus.dx_a;
        r_md_b   <= bus.dx_b;
        r_rd     <= bus.dx_rd;
        r_is_div <= bus.dx_is_div & ~bus.dx_is_mul;
      end
      if (w_capture) begin
        r_res_timeout <= w_timeout;
        if (w_exc_path) begin
          r_res_rd   <= c_status_rd;
          r_res_data <= r_is_div ? c_exc_div : c_exc_mul;
        end else begin
          r_res_rd   <= r_rd;
          r_res_data <= bus.md_result;
        end
      end
    end
  end

  assign bus.md_a         = r_md_a;
  assign bus.md_b         = r_md_b;
  assign bus.md_ctrl_mult = w_start_mul;
  assign bus.md_ctrl_div  = w_start_div;
  assign bus.stall        = w_stall;
  assign bus.xm_bubble    = w_stall;
  assign bus.res_valid    = w_res_valid;
  assign bus.res_data     = r_res_data;
  assign bus.res_rd       = r_res_rd;
  assign bus.res_timeout  = r_res_timeout;

endmodule

`default_nettype wire
